// File: rtl/mode7_pkg.sv
// Shared types, constants and fixed-point conversion helpers for the Mode 7
// coordinate generator.
package mode7_pkg;

    localparam int unsigned SIZE     = 16;
    localparam int unsigned DEC_SIZE = 8;
    localparam int unsigned ACC_W    = 24;

    localparam logic [SIZE-1:0] ROUND_CONST = 16'h0080;
    localparam logic [SIZE-2:0] MAG_MAX     = 15'h7FFF;

    typedef enum logic [2:0] {
        StIdle,
        StSetup0,
        StSetup1,
        StSetup2,
        StSetup3,
        StRun
    } state_e;

    // Sign-magnitude to ACC_W two's complement; negative zero becomes 0.
    function automatic logic [ACC_W-1:0] sm_to_tc(input logic [SIZE-1:0] sm);
        logic [ACC_W-1:0] mag;
        mag = {{(ACC_W-SIZE+1){1'b0}}, sm[SIZE-2:0]};
        return sm[SIZE-1] ? (~mag + 1'b1) : mag;
    endfunction

    // ACC_W two's complement to sign-magnitude with the magnitude clamped to MAG_MAX.
    function automatic logic [SIZE-1:0] tc_to_sm_sat(input logic [ACC_W-1:0] tc);
        logic [ACC_W-1:0] abs_v;
        logic [SIZE-2:0]  mag;
        abs_v = tc[ACC_W-1] ? (~tc + 1'b1) : tc;
        if (abs_v > {{(ACC_W-SIZE+1){1'b0}}, MAG_MAX}) begin
            mag = MAG_MAX;
        end else begin
            mag = abs_v[SIZE-2:0];
        end
        return {tc[ACC_W-1] && (mag != '0), mag};
    endfunction

endpackage

// File: rtl/sm_mul_q8.sv
// Combinational sign-magnitude 8.8 multiplier with round-half-up on the
// dropped fraction bits.
module sm_mul_q8
    import mode7_pkg::*;
(
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] p
);

    localparam int unsigned PW = 2 * (SIZE - 1) + 1;

    logic [PW-1:0] prod_rnd;
    logic          unused_prod;

    always_comb begin
        prod_rnd = PW'(a[SIZE-2:0]) * PW'(b[SIZE-2:0]) + PW'(ROUND_CONST);
    end

    // Magnitude is the rounded product shifted down and truncated to SIZE-1 bits.
    assign p = {a[SIZE-1] ^ b[SIZE-1], prod_rnd[DEC_SIZE +: SIZE-1]};

    assign unused_prod = ^{prod_rnd[PW-1:DEC_SIZE+SIZE-1], prod_rnd[DEC_SIZE-1:0]};

endmodule

// File: rtl/mode7_coord_gen.sv
// Per-scanline Mode 7 texel coordinate generator: four-cycle affine setup on a
// shared multiplier, then one (u, v) per pixel over a valid/ready handshake.
module mode7_coord_gen
    import mode7_pkg::*;
#(
    parameter int unsigned SIZE     = 16,
    parameter int unsigned INT_SIZE = 8,
    parameter int unsigned DEC_SIZE = 8,
    parameter int unsigned H_RES    = 256,
    parameter int unsigned ACC_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                line_start,
    input  logic [7:0]          line_y,
    input  logic [SIZE-1:0]     mat_a,
    input  logic [SIZE-1:0]     mat_b,
    input  logic [SIZE-1:0]     mat_c,
    input  logic [SIZE-1:0]     mat_d,
    input  logic [SIZE-1:0]     org_x,
    input  logic [SIZE-1:0]     org_y,
    input  logic [SIZE-1:0]     scr_h,
    input  logic [SIZE-1:0]     scr_v,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_x,
    output logic [INT_SIZE-1:0] out_u,
    output logic [INT_SIZE-1:0] out_v,
    output logic                line_done
);

    localparam logic [7:0] LAST_X = 8'(H_RES - 1);

    state_e state_q, state_d;

    logic [SIZE-1:0]  mat_a_q, mat_b_q, mat_c_q, mat_d_q;
    logic [SIZE-1:0]  dx_q, dy_q;
    logic [ACC_W-1:0] u_acc_q, u_acc_d;
    logic [ACC_W-1:0] v_acc_q, v_acc_d;
    logic [7:0]       x_q, x_d;
    logic             line_done_q, line_done_d;

    logic             latch;
    logic [ACC_W-1:0] dx_tc, dy_tc;
    logic [SIZE-1:0]  mul_a, mul_b, mul_p;
    logic [ACC_W-1:0] mul_tc;

    assign latch = (state_q == StIdle) && line_start;

    // Deltas are taken from the live inputs in the latch cycle.
    always_comb begin
        dx_tc = sm_to_tc(scr_h) - sm_to_tc(org_x);
        dy_tc = ACC_W'({line_y, {DEC_SIZE{1'b0}}}) + sm_to_tc(scr_v) - sm_to_tc(org_y);
    end

    // Operand select depends on state only, keeping the multiplier off the handshake path.
    always_comb begin
        mul_a = mat_a_q;
        mul_b = dx_q;
        unique case (state_q)
            StSetup0: begin
                mul_a = mat_a_q;
                mul_b = dx_q;
            end
            StSetup1: begin
                mul_a = mat_b_q;
                mul_b = dy_q;
            end
            StSetup2: begin
                mul_a = mat_c_q;
                mul_b = dx_q;
            end
            StSetup3: begin
                mul_a = mat_d_q;
                mul_b = dy_q;
            end
            default: begin
                mul_a = mat_a_q;
                mul_b = dx_q;
            end
        endcase
    end

    sm_mul_q8 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    assign mul_tc = sm_to_tc(mul_p);

    always_comb begin
        state_d     = state_q;
        u_acc_d     = u_acc_q;
        v_acc_d     = v_acc_q;
        x_d         = x_q;
        line_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (line_start) begin
                    state_d = StSetup0;
                    u_acc_d = sm_to_tc(org_x);
                    v_acc_d = sm_to_tc(org_y);
                end
            end
            StSetup0: begin
                u_acc_d = u_acc_q + mul_tc;
                state_d = StSetup1;
            end
            StSetup1: begin
                u_acc_d = u_acc_q + mul_tc;
                state_d = StSetup2;
            end
            StSetup2: begin
                v_acc_d = v_acc_q + mul_tc;
                state_d = StSetup3;
            end
            StSetup3: begin
                v_acc_d = v_acc_q + mul_tc;
                x_d     = '0;
                state_d = StRun;
            end
            StRun: begin
                if (out_ready) begin
                    u_acc_d = u_acc_q + sm_to_tc(mat_a_q);
                    v_acc_d = v_acc_q + sm_to_tc(mat_c_q);
                    x_d     = x_q + 1'b1;
                    if (x_q == LAST_X) begin
                        state_d     = StIdle;
                        line_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mat_a_q     <= '0;
            mat_b_q     <= '0;
            mat_c_q     <= '0;
            mat_d_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            u_acc_q     <= '0;
            v_acc_q     <= '0;
            x_q         <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            u_acc_q     <= u_acc_d;
            v_acc_q     <= v_acc_d;
            x_q         <= x_d;
            line_done_q <= line_done_d;
            if (latch) begin
                mat_a_q <= mat_a;
                mat_b_q <= mat_b;
                mat_c_q <= mat_c;
                mat_d_q <= mat_d;
                dx_q    <= tc_to_sm_sat(dx_tc);
                dy_q    <= tc_to_sm_sat(dy_tc);
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StRun);
    assign out_x     = x_q;
    assign out_u     = u_acc_q[DEC_SIZE +: INT_SIZE];
    assign out_v     = v_acc_q[DEC_SIZE +: INT_SIZE];
    assign line_done = line_done_q;

endmodule
